// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes instr[6:0], produces the
// XLEN-wide immediate, format code, illegal flag and PC-relative target.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic            ill;
    } bundle_t;

    bundle_t     dec_s;
    bundle_t     out_r;
    bundle_t     skid_r;
    logic        out_valid_r;
    logic        skid_valid_r;
    logic [31:0] imm32_s;
    logic        accept_s;
    logic        out_free_s;

    // Opcode decode into a 32-bit immediate; extension to XLEN happens below.
    always_comb begin
        imm32_s     = 32'd0;
        dec_s.fmt   = FMT_NONE;
        dec_s.ill   = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_s.fmt = FMT_I;
                imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_s.fmt = FMT_S;
                imm32_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_s.fmt = FMT_B;
                imm32_s   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_s.fmt = FMT_U;
                imm32_s   = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_s.fmt = FMT_J;
                imm32_s   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1110011: begin
                dec_s.fmt = FMT_Z;
                imm32_s   = {27'd0, in_instr[19:15]};
            end
            7'b0110011, 7'b0001111: begin
                dec_s.fmt = FMT_NONE;
            end
            default: begin
                dec_s.ill = 1'b1;
            end
        endcase

        // The CSR zimm is the only unsigned immediate; all others extend instr[31].
        if (dec_s.fmt == FMT_Z) begin
            dec_s.imm = XLEN'(imm32_s);
        end else begin
            dec_s.imm = XLEN'($signed(imm32_s));
        end

        // JALR is excluded: its base is rs1, which is not known at this stage.
        if ((dec_s.fmt == FMT_B) || (dec_s.fmt == FMT_J) || (in_instr[6:0] == 7'b0010111)) begin
            dec_s.tgt = in_pc + dec_s.imm;
        end else begin
            dec_s.tgt = {XLEN{1'b0}};
        end
        dec_s.pc = in_pc;
    end

    // Upstream ready: blocked by reset, otherwise by a full skid (or a stalled output without one).
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (SKID_EN) begin
            in_ready = !skid_valid_r;
        end else begin
            in_ready = !out_valid_r || out_ready;
        end
    end

    assign accept_s   = in_valid && in_ready;
    assign out_free_s = !out_valid_r || out_ready;

    // Output register and skid: the skid always drains ahead of new input to keep FIFO order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            out_r        <= '{default: '0};
            skid_r       <= '{default: '0};
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s && SKID_EN) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_imm     = out_r.imm;
    assign out_fmt     = out_r.fmt;
    assign out_target  = out_r.tgt;
    assign out_illegal = out_r.ill;
    assign out_pc      = out_r.pc;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate generator.
- Accepts one 32-bit instruction plus its PC per valid/ready handshake. Emits the sign-extended immediate at XLEN width, a format code, an illegal-opcode flag and the PC-relative target.
- Sits between fetch and decode/execute.
- Has one registered output stage plus a 1-entry skid buffer, giving full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. All sign extension uses instr[31].
- SKID_EN, 1, 1 = 1-entry skid buffer (full throughput). 0 = no skid, so in_ready = !out_valid || out_ready.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  block can accept this cycle
- in_instr  input  32  raw instruction
- in_pc  input  XLEN  PC of in_instr
- out_valid  output  1  output bundle valid
- out_ready  input  1  downstream accepts the bundle
- out_imm  output  XLEN  generated immediate
- out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
- out_target  output  XLEN  in_pc+out_imm for B/J/AUIPC, else 0
- out_illegal  output  1  opcode not recognised
- out_pc  output  XLEN  PC carried through

Behaviour:
- Decode is by instr[6:0] only.
  - 0010011, 0000011, 1100111 -> I: sext(instr[31:20]).
  - 0100011 -> S: sext({instr[31:25], instr[11:7]}).
  - 1100011 -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111 -> U: sext({instr[31:12], 12'b0}). For XLEN=64, upper 32 bits = instr[31].
  - 1101111 -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 1110011 -> Z: zero-extended instr[19:15].
  - 0110011, 0001111 -> NONE, imm 0, legal.
  - Anything else -> NONE, imm 0, out_illegal = 1.
- Target:
  - in_pc + imm, modulo 2^XLEN (wrap, no carry out).
  - Computed only for B, J and opcode 0010111 (AUIPC); 0 otherwise. JALR target is 0 because rs1 is unknown here.
- Latency: a transfer accepted at edge N (in_valid && in_ready) is presented on the out_* ports after edge N, i.e. valid in cycle N+1, when the output stage was empty or draining.
- Output stability: while out_valid && !out_ready, every out_* port holds constant.
- Skid (SKID_EN=1):
  - in_ready = !skid_valid.
  - An accept while the output is stalled is stored in the skid.
  - When the output drains, the skid moves to the output on the same edge.
  - A simultaneous new accept in that cycle is allowed only if the skid was empty. Otherwise in_ready = 0 already blocks it.
  - Strict FIFO order, no drop, no duplicate.
- Simultaneous accept and drain with the skid empty: the output register reloads with the new bundle and out_valid stays 1.
- Reset (sync, any cycle, including mid-transfer):
  - At the next edge: out_valid = 0, skid_valid = 0, and out_imm, out_fmt, out_target, out_illegal, out_pc all = 0.
  - in_ready = 0 while rst is high, 1 in the first cycle after rst deasserts.
  - In-flight data is discarded.
- out_* data ports are don't-care-free: when out_valid = 0 they hold their last value, or 0 after reset.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), XLEN=32, out_ready=1 -> after 1 cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0, target=0.
- 0xFE000EE3 (beq x0,x0,-4), pc=0x00000100 -> imm=0xFFFFFFFC, fmt=3, target=0x000000FC. Repeat with pc=0x00000000 -> target=0xFFFFFFFC (wrap).
- XLEN=64, 0x80000037 (lui) -> imm=0xFFFFFFFF80000000, fmt=4. Then 0x000FD073 (csrrwi, rs1=31) -> imm=0x1F, fmt=6.
- Backpressure: hold out_ready=0, stream A=0xFFF00093, B=0x80000037, C=0x0000007F.
  - A is held on the outputs, B lands in the skid, and in_ready=0 so C stalls.
  - Release out_ready -> A, B, C emerge in order on consecutive cycles.
  - C shows illegal=1, imm=0, fmt=0.
- Back-to-back throughput: 8 instructions with in_valid=out_ready=1 every cycle -> 8 outputs in 8 consecutive cycles, no bubbles.
- Reset mid-operation: assert rst for 1 cycle while the output and skid are full -> next cycle out_valid=0, all data outputs 0, in_ready=1 after release. No stale bundle appears afterwards.
